// File: rtl/mult_bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_bist_pkg
//  Description : Shared types and constants for the multiplier BIST sequencer.
//                - FSM state encoding.
//                - Galois LFSR feedback mask and a one-step helper.
//                - Corner-vector selector encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_bist_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CALC  = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } bist_state_t;

   // x^64 + x^63 + x^61 + x^60 + 1, right-shifting Galois form.
   // The mask is fixed whatever the operand width.
   localparam logic [63:0] c_lfsr_mask = 64'hD800_0000_0000_0000;

   // Number of fixed corner vectors replayed before the random ones
   localparam int c_num_corners = 4;

   // Corner vector selected by the low two bits of the vector counter
   typedef enum logic [1:0] {
      CORNER_ZERO_ZERO = 2'd0,   // (0, 0)
      CORNER_MAX_MAX   = 2'd1,   // (max, max)
      CORNER_MAX_ONE   = 2'd2,   // (max, 1)
      CORNER_ONE_MAX   = 2'd3    // (1, max)
   } corner_sel_t;

   // One step of the right-shifting Galois LFSR
   function automatic logic [63:0] lfsr64_next(input logic [63:0] s);
      lfsr64_next = s[0] ? ((s >> 1) ^ c_lfsr_mask) : (s >> 1);
   endfunction

endpackage : mult_bist_pkg
`default_nettype wire

// File: rtl/mult_bist_lfsr64.sv
`default_nettype none
// ============================================================================
//  Module      : mult_bist_lfsr64
//  Description : 64-bit right-shifting Galois LFSR operand generator.
//                A zero seed would lock the register up, so it is replaced
//                by 1.
//  Ports       : clk      - clock
//                i_reload - synchronous load of the seed (highest priority)
//                i_step   - advance one LFSR step
//                o_state  - current 64-bit LFSR state
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_bist_lfsr64
   import mult_bist_pkg::*;
#(
   parameter logic [63:0] SEED = 64'h0000_0000_0000_0001
) (
   input  logic        clk,
   input  logic        i_reload,
   input  logic        i_step,
   output logic [63:0] o_state
);

   localparam logic [63:0] c_seed = (SEED == 64'd0) ? 64'd1 : SEED;

   logic [63:0] r_state;

   always_ff @(posedge clk) begin
      if (i_reload) begin
         r_state <= c_seed;
      end else if (i_step) begin
         r_state <= lfsr64_next(r_state);
      end
   end

   assign o_state = r_state;

endmodule : mult_bist_lfsr64
`default_nettype wire

// File: rtl/mult_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mult_bist_ctrl
//  Description : BIST sequencer for a combinational multiplier.
//                Replays four corner vectors, then LFSR-generated vectors.
//                Each product is checked against a sequential shift-add
//                golden multiplier. The block reports pass/fail, a saturating
//                error count and the first failing vector.
//  Ports       : clk          - clock
//                rst          - synchronous active-high reset
//                i_start      - run request, sampled in IDLE and DONE only
//                o_dut_a/b    - registered operands to the multiplier
//                i_dut_prod   - product returned by the multiplier
//                o_busy       - run in progress (LOAD/CALC/CHECK)
//                o_done       - run finished
//                o_pass       - no mismatches, valid while o_done
//                o_err_count  - saturating mismatch count
//                o_fail_a/b   - operands of the first mismatch
//                o_fail_prod  - multiplier product of the first mismatch
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_bist_ctrl
   import mult_bist_pkg::*;
#(
   parameter int          WIDTH       = 8,
   parameter int          NUM_VECTORS = 10000,
   parameter logic [63:0] SEED_A      = 64'h0123_4567_89AB_CDEF,
   parameter logic [63:0] SEED_B      = 64'hFEDC_BA98_7654_3210,
   parameter int          ERR_W       = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   output logic [WIDTH-1:0]     o_dut_a,
   output logic [WIDTH-1:0]     o_dut_b,
   input  logic [2*WIDTH-1:0]   i_dut_prod,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_pass,
   output logic [ERR_W-1:0]     o_err_count,
   output logic [WIDTH-1:0]     o_fail_a,
   output logic [WIDTH-1:0]     o_fail_b,
   output logic [2*WIDTH-1:0]   o_fail_prod
);

   localparam int c_pw    = 2 * WIDTH;
   localparam int c_cnt_w = $clog2(NUM_VECTORS + 1);
   localparam int c_bit_w = $clog2(WIDTH + 1);

   localparam logic [c_cnt_w-1:0] c_last_vec   = c_cnt_w'(NUM_VECTORS - 1);
   localparam logic [c_cnt_w-1:0] c_corner_end = c_cnt_w'(c_num_corners);
   localparam logic [c_bit_w-1:0] c_last_bit   = c_bit_w'(WIDTH - 1);
   localparam logic [WIDTH-1:0]   c_max        = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0]   c_one        = WIDTH'(1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   bist_state_t          r_state;
   bist_state_t          w_next_state;

   logic [c_cnt_w-1:0]   r_vec_cnt;
   logic [c_bit_w-1:0]   r_bit_cnt;
   logic [c_pw-1:0]      r_acc;
   logic [c_pw-1:0]      r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [WIDTH-1:0]     r_dut_a;
   logic [WIDTH-1:0]     r_dut_b;
   logic [ERR_W-1:0]     r_err_cnt;
   logic                 r_first_fail;
   logic [WIDTH-1:0]     r_fail_a;
   logic [WIDTH-1:0]     r_fail_b;
   logic [c_pw-1:0]      r_fail_prod;

   logic [63:0]          w_lfsr_a;
   logic [63:0]          w_lfsr_b;
   logic                 w_lfsr_step;
   logic                 w_is_corner;
   corner_sel_t          w_corner_sel;
   logic [WIDTH-1:0]     w_load_a;
   logic [WIDTH-1:0]     w_load_b;
   logic                 w_run_start;
   logic                 w_mismatch;

   // ------------------------------------------------------------------------
   // Operand generators. Reset is the only reseed: a restart from DONE
   // continues the pseudo-random sequence.
   // ------------------------------------------------------------------------
   assign w_is_corner  = (r_vec_cnt < c_corner_end);
   assign w_lfsr_step  = (r_state == ST_LOAD) && !w_is_corner;
   assign w_corner_sel = corner_sel_t'(r_vec_cnt[1:0]);

   mult_bist_lfsr64 #(
      .SEED     (SEED_A)
   ) u_lfsr_a (
      .clk      (clk),
      .i_reload (rst),
      .i_step   (w_lfsr_step),
      .o_state  (w_lfsr_a)
   );

   mult_bist_lfsr64 #(
      .SEED     (SEED_B)
   ) u_lfsr_b (
      .clk      (clk),
      .i_reload (rst),
      .i_step   (w_lfsr_step),
      .o_state  (w_lfsr_b)
   );

   // Upper LFSR bits beyond the operand width are intentionally dropped
   generate
      if (WIDTH < 64) begin : g_unused_lfsr_hi
         logic w_unused_lfsr_hi;
         assign w_unused_lfsr_hi = ^{w_lfsr_a[63:WIDTH], w_lfsr_b[63:WIDTH]};
      end
   endgenerate

   // Operand selection for the vector about to be loaded
   always_comb begin
      w_load_a = w_lfsr_a[WIDTH-1:0];
      w_load_b = w_lfsr_b[WIDTH-1:0];
      if (w_is_corner) begin
         case (w_corner_sel)
            CORNER_ZERO_ZERO: begin w_load_a = '0;    w_load_b = '0;    end
            CORNER_MAX_MAX:   begin w_load_a = c_max; w_load_b = c_max; end
            CORNER_MAX_ONE:   begin w_load_a = c_max; w_load_b = c_one; end
            CORNER_ONE_MAX:   begin w_load_a = c_one; w_load_b = c_max; end
            default:          begin w_load_a = '0;    w_load_b = '0;    end
         endcase
      end
   end

   assign w_run_start = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && i_start;
   assign w_mismatch  = (i_dut_prod != r_acc);

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (i_start) w_next_state = ST_LOAD;
         ST_LOAD:  w_next_state = ST_CALC;
         // One multiplier bit per CALC cycle, WIDTH cycles in total
         ST_CALC:  if (r_bit_cnt == c_last_bit) w_next_state = ST_CHECK;
         ST_CHECK: w_next_state = (r_vec_cnt == c_last_vec) ? ST_DONE : ST_LOAD;
         ST_DONE:  if (i_start) w_next_state = ST_LOAD;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      o_busy = 1'b0;
      o_done = 1'b0;
      case (r_state)
         ST_LOAD, ST_CALC, ST_CHECK: o_busy = 1'b1;
         ST_DONE:                    o_done = 1'b1;
         default:                    ;
      endcase
      o_pass = o_done && (r_err_cnt == '0);
   end

   // ------------------------------------------------------------------------
   // Golden shift-add datapath, operand registers and result capture
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vec_cnt    <= '0;
         r_bit_cnt    <= '0;
         r_acc        <= '0;
         r_mcand      <= '0;
         r_mplier     <= '0;
         r_dut_a      <= '0;
         r_dut_b      <= '0;
         r_err_cnt    <= '0;
         r_first_fail <= 1'b0;
         r_fail_a     <= '0;
         r_fail_b     <= '0;
         r_fail_prod  <= '0;
      end else begin
         if (w_run_start) begin
            r_vec_cnt    <= '0;
            r_err_cnt    <= '0;
            r_first_fail <= 1'b0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
            r_fail_prod  <= '0;
         end

         case (r_state)
            ST_LOAD: begin
               r_dut_a   <= w_load_a;
               r_dut_b   <= w_load_b;
               r_acc     <= '0;
               r_mcand   <= {{WIDTH{1'b0}}, w_load_a};
               r_mplier  <= w_load_b;
               r_bit_cnt <= '0;
            end
            ST_CALC: begin
               if (r_mplier[0]) begin
                  r_acc <= r_acc + r_mcand;
               end
               r_mcand   <= r_mcand << 1;
               r_mplier  <= r_mplier >> 1;
               r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
            end
            ST_CHECK: begin
               if (w_mismatch) begin
                  // Saturate rather than wrap so a long run never reads clean
                  if (r_err_cnt != {ERR_W{1'b1}}) begin
                     r_err_cnt <= r_err_cnt + ERR_W'(1);
                  end
                  if (!r_first_fail) begin
                     r_first_fail <= 1'b1;
                     r_fail_a     <= r_dut_a;
                     r_fail_b     <= r_dut_b;
                     r_fail_prod  <= i_dut_prod;
                  end
               end
               r_vec_cnt <= r_vec_cnt + c_cnt_w'(1);
            end
            default: ;
         endcase
      end
   end

   assign o_dut_a     = r_dut_a;
   assign o_dut_b     = r_dut_b;
   assign o_err_count = r_err_cnt;
   assign o_fail_a    = r_fail_a;
   assign o_fail_b    = r_fail_b;
   assign o_fail_prod = r_fail_prod;

endmodule : mult_bist_ctrl
`default_nettype wire

// File: tb/tb_mult_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_bist_ctrl
//  Description : Self-checking bench for mult_bist_ctrl. A behavioural
//                model tracks the expected outputs in terms of edges since
//                start. A multiplier model with selectable faults drives the
//                product input.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_bist_ctrl;

   localparam int          W  = 8;
   localparam int          N  = 20;
   localparam int          EW = 4;
   localparam int          VC = W + 2;
   localparam logic [63:0] SA = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] SB = 64'hFEDC_BA98_7654_3210;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [W-1:0]    dut_a, dut_b, fail_a, fail_b;
   logic [2*W-1:0]  dut_prod, fail_prod;
   logic            busy, done, pass;
   logic [EW-1:0]   err_count;
   int              fault_mode;   // 0 correct, 1 bit0 stuck-at-1, 2 bit0 inverted

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mult_bist_ctrl #(
      .WIDTH       (W),
      .NUM_VECTORS (N),
      .SEED_A      (SA),
      .SEED_B      (SB),
      .ERR_W       (EW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (start),
      .o_dut_a     (dut_a),
      .o_dut_b     (dut_b),
      .i_dut_prod  (dut_prod),
      .o_busy      (busy),
      .o_done      (done),
      .o_pass      (pass),
      .o_err_count (err_count),
      .o_fail_a    (fail_a),
      .o_fail_b    (fail_b),
      .o_fail_prod (fail_prod)
   );

   // ---------------------------------------------------------------------
   // Multiplier under test (behavioural, with optional fault)
   // ---------------------------------------------------------------------
   function automatic logic [2*W-1:0] mul_out(input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input int mode);
      logic [2*W-1:0] p;
      p = (2*W)'(a) * (2*W)'(b);
      case (mode)
         1:       mul_out = p | (2*W)'(1);
         2:       mul_out = p ^ (2*W)'(1);
         default: mul_out = p;
      endcase
   endfunction

   always_comb dut_prod = mul_out(dut_a, dut_b, fault_mode);

   function automatic logic [63:0] lfsr_step(input logic [63:0] s);
      lfsr_step = s[0] ? ((s >> 1) ^ 64'hD800_0000_0000_0000) : (s >> 1);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model: m_t counts edges since the edge that took start.
   // Vector k is loaded at edge 1+k*VC and checked at edge (k+1)*VC.
   // ---------------------------------------------------------------------
   bit             m_valid = 1'b0;
   bit             m_active, m_done, m_ff;
   int             m_t, m_err;
   logic [W-1:0]   m_a, m_b, m_fa, m_fb;
   logic [2*W-1:0] m_fp;
   logic [63:0]    m_la, m_lb;

   always @(posedge clk) begin
      if (rst) begin
         m_valid = 1'b1; m_active = 1'b0; m_done = 1'b0; m_ff = 1'b0;
         m_t = 0; m_err = 0; m_a = '0; m_b = '0;
         m_fa = '0; m_fb = '0; m_fp = '0;
         m_la = SA; m_lb = SB;
      end else if (m_active) begin
         m_t++;
         if ((m_t - 1) % VC == 0) begin
            int k;
            k = (m_t - 1) / VC;
            if (k == 0)      begin m_a = 8'h00; m_b = 8'h00; end
            else if (k == 1) begin m_a = 8'hFF; m_b = 8'hFF; end
            else if (k == 2) begin m_a = 8'hFF; m_b = 8'h01; end
            else if (k == 3) begin m_a = 8'h01; m_b = 8'hFF; end
            else begin
               m_a = m_la[W-1:0]; m_b = m_lb[W-1:0];
               m_la = lfsr_step(m_la); m_lb = lfsr_step(m_lb);
            end
         end
         if (m_t % VC == 0) begin
            logic [2*W-1:0] got;
            got = mul_out(m_a, m_b, fault_mode);
            if (got != (2*W)'(m_a) * (2*W)'(m_b)) begin
               if (m_err < (1 << EW) - 1) m_err++;
               if (!m_ff) begin m_ff = 1'b1; m_fa = m_a; m_fb = m_b; m_fp = got; end
            end
            if (m_t == N * VC) begin m_active = 1'b0; m_done = 1'b1; end
         end
      end else if (start) begin
         m_active = 1'b1; m_done = 1'b0; m_t = 0; m_err = 0;
         m_ff = 1'b0; m_fa = '0; m_fb = '0; m_fp = '0;
      end
   end

   // Compare process: every cycle, away from the active edge
   always @(negedge clk) begin
      if (m_valid) begin
         check("busy",      64'(busy),      64'(m_active));
         check("done",      64'(done),      64'(m_done));
         check("pass",      64'(pass),      64'(m_done && m_err == 0));
         check("err_count", 64'(err_count), 64'(m_err));
         check("dut_a",     64'(dut_a),     64'(m_a));
         check("dut_b",     64'(dut_b),     64'(m_b));
         check("fail_a",    64'(fail_a),    64'(m_fa));
         check("fail_b",    64'(fail_b),    64'(m_fb));
         check("fail_prod", 64'(fail_prod), 64'(m_fp));
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   logic [W-1:0] cap_a [8];
   logic [W-1:0] cap_b [8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts a run; abort_at > 0 asserts reset after that many edges.
   task automatic run(input bit hold, input int abort_at, output int edges);
      bit seen_done;
      seen_done = 1'b0;
      start = 1'b1;
      tick();                       // edge that samples start
      if (!hold) start = 1'b0;
      edges = 0;
      for (int e = 1; e <= N * VC + 50; e++) begin
         tick();
         edges = e;
         if ((e - 1) % VC == 0 && (e - 1) / VC < 8) begin
            cap_a[(e - 1) / VC] = dut_a;
            cap_b[(e - 1) / VC] = dut_b;
         end
         if (e == abort_at) begin
            start = 1'b0;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            return;
         end
         if (done) begin
            seen_done = 1'b1;
            break;
         end
      end
      start = 1'b0;
      check("run_done_within_budget", 64'(seen_done), 64'd1);
   endtask

   int edges;

   initial begin
      rst = 1'b1; start = 1'b0; fault_mode = 0;
      repeat (3) tick();
      rst = 1'b0;
      check("reset_busy",  64'(busy),      64'd0);
      check("reset_done",  64'(done),      64'd0);
      check("reset_err",   64'(err_count), 64'd0);
      check("reset_dut_a", 64'(dut_a),     64'd0);

      // Run A: correct multiplier, corner sequence and first random vector
      repeat ($urandom_range(0, 4)) tick();
      run(1'b0, 0, edges);
      check("A_edges_to_done", 64'(edges), 64'(N * VC));
      check("A_c0_a", 64'(cap_a[0]), 64'h00); check("A_c0_b", 64'(cap_b[0]), 64'h00);
      check("A_c1_a", 64'(cap_a[1]), 64'hFF); check("A_c1_b", 64'(cap_b[1]), 64'hFF);
      check("A_c2_a", 64'(cap_a[2]), 64'hFF); check("A_c2_b", 64'(cap_b[2]), 64'h01);
      check("A_c3_a", 64'(cap_a[3]), 64'h01); check("A_c3_b", 64'(cap_b[3]), 64'hFF);
      check("A_r4_a", 64'(cap_a[4]), 64'hEF); check("A_r4_b", 64'(cap_b[4]), 64'h10);
      check("A_pass", 64'(pass), 64'd1);
      check("A_err",  64'(err_count), 64'd0);

      // Run B: bit0 stuck-at-1, start held high for the whole run
      fault_mode = 1;
      run(1'b1, 0, edges);
      check("B_fail_a",    64'(fail_a),    64'h00);
      check("B_fail_b",    64'(fail_b),    64'h00);
      check("B_fail_prod", 64'(fail_prod), 64'h0001);
      check("B_pass",      64'(pass),      64'd0);
      tick();
      check("B_stays_done", 64'(done), 64'd1);

      // Run C: restart from DONE with a correct multiplier
      fault_mode = 0;
      repeat ($urandom_range(0, 4)) tick();
      run(1'b0, 0, edges);
      check("C_err",  64'(err_count), 64'd0);
      check("C_pass", 64'(pass),      64'd1);

      // Run D: every product wrong, counter saturates
      fault_mode = 2;
      run(1'b0, 0, edges);
      check("D_err_sat",   64'(err_count), 64'hF);
      check("D_fail_a",    64'(fail_a),    64'h00);
      check("D_fail_prod", 64'(fail_prod), 64'h0001);

      // Run E: reset during CALC of vector 2, then a clean rerun
      fault_mode = 0;
      run(1'b0, 1 + 2 * VC + 3, edges);
      check("E_abort_busy", 64'(busy),      64'd0);
      check("E_abort_done", 64'(done),      64'd0);
      check("E_abort_a",    64'(dut_a),     64'd0);
      check("E_abort_err",  64'(err_count), 64'd0);
      run(1'b0, 0, edges);
      check("E_c0_a", 64'(cap_a[0]), 64'h00);
      check("E_r4_a", 64'(cap_a[4]), 64'hEF);
      check("E_r4_b", 64'(cap_b[4]), 64'h10);

      // Randomised runs: fault mode, hold, gaps and random aborts
      for (int r = 0; r < 5; r++) begin
         fault_mode = int'($urandom_range(0, 2));
         repeat ($urandom_range(0, 5)) tick();
         run(1'($urandom_range(0, 1)),
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, N * VC - 1)) : 0,
             edges);
      end

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
      $fatal(1);
   end

endmodule : tb_mult_bist_ctrl
`default_nettype wire
